// File: rtl/comparator_seq.sv
// Sequential magnitude comparator: evaluates CHUNK bits per cycle, MSB chunk first,
// and stops at the first differing chunk. Signed compares flip the operand MSBs at latch time.
module comparator_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [2:0]       cm
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [IW-1:0]    idx_r, idx_s;
   logic [WIDTH-1:0] a_r, a_s;
   logic [WIDTH-1:0] b_r, b_s;
   logic [2:0]       cm_r, cm_s;
   logic             busy_r;
   logic             done_r;
   logic [CHUNK-1:0] a_top_s;
   logic [CHUNK-1:0] b_top_s;

   // The latched operands shift left after each equal chunk, so the live chunk is always on top.
   assign a_top_s = a_r[WIDTH-1 -: CHUNK];
   assign b_top_s = b_r[WIDTH-1 -: CHUNK];

   // Next-state, operand shifting and result selection.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      a_s     = a_r;
      b_s     = b_r;
      cm_s    = cm_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               a_s     = a ^ (signed_mode ? MSB_MASK : {WIDTH{1'b0}});
               b_s     = b ^ (signed_mode ? MSB_MASK : {WIDTH{1'b0}});
               idx_s   = IW'(NCHUNK - 1);
               state_s = COMPARE;
            end else begin
               state_s = IDLE;
            end
         end
         COMPARE: begin
            if (a_top_s > b_top_s) begin
               cm_s    = 3'b100;
               state_s = DONE;
            end else if (a_top_s < b_top_s) begin
               cm_s    = 3'b001;
               state_s = DONE;
            end else if (idx_r == {IW{1'b0}}) begin
               cm_s    = 3'b010;
               state_s = DONE;
            end else begin
               idx_s   = idx_r - IW'(1);
               a_s     = a_r << CHUNK;
               b_s     = b_r << CHUNK;
               state_s = COMPARE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and output registers; busy/done are decoded from the next state so they track state_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         idx_r   <= {IW{1'b0}};
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         cm_r    <= 3'b000;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         a_r     <= a_s;
         b_r     <= b_s;
         cm_r    <= cm_s;
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == DONE);
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign cm   = cm_r;

endmodule

// File: tb/tb_comparator_seq.sv
// Scoreboard bench for comparator_seq: stimulus pushes expected results, a negedge monitor
// pops and compares on every done pulse and checks busy/cm holding every cycle.
module tb_comparator_seq;

   localparam int W = 16;
   localparam int C = 4;
   localparam int N = W / C;

   typedef struct {
      logic [2:0] cm;
      int         done_at;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          signed_mode;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [2:0]    cm;

   exp_t          q[$];
   int            edge_cnt   = 0;
   int            free_edge  = 0;
   int            busy_lo    = 1;
   int            busy_hi    = 0;
   logic [2:0]    hold_cm    = 3'b000;
   int            compared   = 0;
   int            mismatched = 0;

   comparator_seq #(.WIDTH(W), .CHUNK(C)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .signed_mode(signed_mode),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .cm         (cm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Reference: plain integer comparison, and latency from the count of leading equal chunks.
   function automatic logic [2:0] ref_cm(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
      int xi, yi;
      if (sm) begin
         xi = int'($signed(x));
         yi = int'($signed(y));
      end else begin
         xi = int'(x);
         yi = int'(y);
      end
      if (xi < yi) return 3'b001;
      else if (xi == yi) return 3'b010;
      else return 3'b100;
   endfunction

   function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
      int eq = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (x[k*C +: C] == y[k*C +: C]) eq++;
         else break;
      end
      return (eq == N) ? N : eq + 1;
   endfunction

   // Wait (driving noise that must be ignored) until the model says the block is idle, then start.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ism,
                        input logic [2:0] ecm, input int elat);
      exp_t e;
      int   n0;
      while (edge_cnt + 1 < free_edge) begin
         start       = 1'($urandom_range(0, 1));
         a           = W'($urandom);
         b           = W'($urandom);
         signed_mode = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      start       = 1'b1;
      a           = ia;
      b           = ib;
      signed_mode = ism;
      n0          = edge_cnt + 1;
      e.cm        = ecm;
      e.done_at   = n0 + elat;
      q.push_back(e);
      busy_lo     = n0;
      busy_hi     = n0 + elat;
      free_edge   = n0 + elat + 2;
      @(posedge clk); #1;
      start       = 1'b0;
   endtask

   task automatic issue_model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ism);
      issue(ia, ib, ism, ref_cm(ia, ib, ism), ref_lat(ia, ib));
   endtask

   // Monitor: checks done timing, result, cm holding and busy on every falling edge out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         if (q.size() > 0 && q[0].done_at == edge_cnt) begin
            chk("done_pulse", int'(done), 1);
            chk("cm_result", int'(cm), int'(q[0].cm));
            hold_cm = q[0].cm;
            q.delete(0);
         end else begin
            chk("done_quiet", int'(done), 0);
            chk("cm_hold", int'(cm), int'(hold_cm));
         end
         chk("busy", int'(busy), int'(edge_cnt >= busy_lo && edge_cnt <= busy_hi));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] ra, rb, tmp;
      int           k;
      rst_n       = 1'b0;
      start       = 1'b0;
      signed_mode = 1'b0;
      a           = 16'h0000;
      b           = 16'h0000;
      #2;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_cm", int'(cm), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed cases with hand-derived results and latencies.
      issue(16'h1234, 16'h1234, 1'b0, 3'b010, 4);
      issue(16'h8000, 16'h7FFF, 1'b0, 3'b100, 1);
      issue(16'h8000, 16'h7FFF, 1'b1, 3'b001, 1);
      issue(16'h1235, 16'h1234, 1'b0, 3'b100, 4);
      issue(16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 4);
      issue(16'h0001, 16'h0002, 1'b0, 3'b001, 4);
      start = 1'b1;
      a     = 16'hF000;
      b     = 16'h0000;
      @(posedge clk); #1;
      start = 1'b0;

      // Reset in the middle of a compare aborts it without a done pulse.
      issue(16'h5555, 16'h5555, 1'b0, 3'b010, 4);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_cm", int'(cm), 0);
      q.delete();
      hold_cm   = 3'b000;
      busy_lo   = 1;
      busy_hi   = 0;
      free_edge = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(16'h00FF, 16'h0100, 1'b0, 3'b001, 2);

      // Randomized requests biased towards long runs of equal chunks.
      for (int i = 0; i < 300; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0: rb = W'($urandom);
            1: rb = ra;
            2: begin
               tmp = ra;
               k   = $urandom_range(0, N - 1);
               tmp[k*C +: C] = C'($urandom);
               rb  = tmp;
            end
            default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
         endcase
         repeat ($urandom_range(0, 2)) begin
            if (edge_cnt + 1 >= free_edge) begin
               start = 1'b0;
               @(posedge clk); #1;
            end
         end
         issue_model(ra, rb, 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      @(posedge clk); #1;
      chk("drain_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/comparator_seq.md
COMPARATOR_SEQ -- requirements
Module: comparator_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4: bits compared per cycle.
REQ-003 WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK SHALL be at least 1.
REQ-004 Port list, clock and reset first:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a comparison.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  single-cycle result-valid pulse.
- cm  output  3  result: cm[0] A<B, cm[1] A=B, cm[2] A>B.

Function
REQ-005 FSM states SHALL be IDLE, COMPARE and DONE.
REQ-006 In IDLE, when start=1 at a rising edge:
- a, b and signed_mode SHALL be latched into internal registers.
- The chunk index SHALL be set to NCHUNK-1 (the MSB chunk).
- The FSM SHALL move to COMPARE.
REQ-007 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-008 In COMPARE, each edge SHALL evaluate exactly one CHUNK-bit slice of the latched operands, MSB chunk first.
REQ-009 When signed_mode is latched as 1, bit WIDTH-1 of both latched operands SHALL be inverted before compare, so no separate sign logic is needed.
REQ-010 If the slices differ, cm SHALL be loaded with one-hot 100 (A>B) or 001 (A<B) and the FSM SHALL go to DONE (early termination).
REQ-011 If the slices are equal and the index is 0, cm SHALL be loaded with 010 and the FSM SHALL go to DONE.
REQ-012 If the slices are equal and the index is greater than 0, the index SHALL decrement and the FSM SHALL stay in COMPARE.
REQ-013 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-014 done SHALL be a Moore output, decoded from state DONE only.
REQ-015 Latency: with j leading equal chunks, done SHALL be high in the cycle following edge j+1 after the start edge; worst case (all equal) is edge NCHUNK.
REQ-016 cm SHALL hold its value from the DONE entry until the next result load; it SHALL NOT change during a subsequent COMPARE.
REQ-017 cm SHALL always be one-hot after the first result; 000 means no result since reset.
REQ-018 start SHALL be ignored in COMPARE and DONE, and changes on a, b or signed_mode during those states SHALL NOT affect the result.
REQ-019 busy SHALL be 1 in COMPARE and DONE and 0 in IDLE; a new start is accepted on the first cycle busy=0.

Reset
REQ-020 rst_n=0 SHALL immediately force:
- state to IDLE;
- busy, done and cm to 0;
- the chunk index and latched operands to 0.
REQ-021 Reset asserted mid-COMPARE or in DONE SHALL abort the comparison with no done pulse.
REQ-022 After rst_n deasserts, the first start SHALL be accepted normally.

Verification (WIDTH=16, CHUNK=4)
REQ-023 a=0x1234, b=0x1234, unsigned, start pulse -> 4 COMPARE cycles, then done=1 for one cycle, cm=010, busy high for 5 cycles.
REQ-024 a=0x8000, b=0x7FFF, unsigned -> done after 1 COMPARE cycle, cm=100; same operands with signed_mode=1 -> cm=001.
REQ-025 a=0x1235, b=0x1234 -> difference in the last chunk, 4 COMPARE cycles, cm=100; a=0xFFFF, b=0xFFFE, signed -> cm=100 (-1 > -2).
REQ-026 start a=0x0001, b=0x0002, then pulse start with a=0xF000, b=0x0000 while busy -> second request ignored; cm=001; no second done pulse.
REQ-027 rst_n low during COMPARE -> busy=0, done=0 and cm=000 immediately with no done pulse; after release, a=0x00FF, b=0x0100 -> cm=001 after 2 COMPARE cycles.
